// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and sizing for the decode-stage hazard controller and its
// in-order scoreboard queue.
package common;

    localparam int SB_DEPTH = 4;

    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_HOLD = 1'b1
    } hazard_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    // Single-step modulo for ring indices; idx is always below 2*depth here.
    function automatic int sb_wrap(input int idx, input int depth);
        return (idx >= depth) ? idx - depth : idx;
    endfunction

endpackage

// File: rtl/decode_hazard_ctrl_sb_queue.sv
// In-order ring of pending register writes: push at tail, checked pop at head,
// and truncation to the oldest N entries on a mispredict.
module sb_queue
    import common::*;
#(
    parameter int DEPTH = common::SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [4:0]             i_push_rd,
    input  logic                   i_pop_req,
    input  logic [4:0]             i_pop_id,
    input  logic                   i_trunc,
    input  logic [2:0]             i_keep,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_pop_ok,
    output logic [31:0]            o_busy,
    output logic [31:0]            o_busy_nohead
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] r_head;
    logic [CNT_W-1:0] r_count;
    logic             r_valid [DEPTH];
    logic [4:0]       r_rd    [DEPTH];

    logic [PTR_W-1:0] w_head_next;
    logic [PTR_W-1:0] w_tail;
    logic [CNT_W-1:0] w_cnt_pop;
    logic [CNT_W-1:0] w_count_next;
    logic             w_valid_next [DEPTH];
    logic             w_push;
    logic             w_pop_ok;
    sb_entry_t        w_ent [DEPTH];

    // Pop depends only on stored state and writeback, so it can feed issue logic.
    assign w_pop_ok = i_pop_req && (r_count != '0) && (r_rd[r_head] == i_pop_id);
    assign o_pop_ok = w_pop_ok;
    assign o_count  = r_count;

    always_comb begin
        w_push       = i_push && !i_trunc;
        w_head_next  = w_pop_ok ? PTR_W'(sb_wrap(int'(r_head) + 1, DEPTH)) : r_head;
        w_tail       = PTR_W'(sb_wrap(int'(r_head) + int'(r_count), DEPTH));
        w_cnt_pop    = r_count - CNT_W'(w_pop_ok);
        w_count_next = w_cnt_pop + CNT_W'(w_push);
        if (i_trunc && (int'(i_keep) < int'(w_cnt_pop)))
            w_count_next = CNT_W'(i_keep);
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_next[i] = (((i >= int'(w_head_next)) ? i - int'(w_head_next)
                                : i + DEPTH - int'(w_head_next)) < int'(w_count_next));
        end
    end

    always_comb begin
        o_busy        = '0;
        o_busy_nohead = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent[i] = '{valid: r_valid[i], rd: r_rd[i]};
            if (w_ent[i].valid) begin
                o_busy[w_ent[i].rd] = 1'b1;
                if (i != int'(r_head))
                    o_busy_nohead[w_ent[i].rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_valid[i] <= 1'b0;
        end else begin
            r_head  <= w_head_next;
            r_count <= w_count_next;
            for (int i = 0; i < DEPTH; i++)
                r_valid[i] <= w_valid_next[i];
        end
    end

    // Register ids are payload; validity alone defines occupancy.
    always_ff @(posedge clk) begin
        if (w_push)
            r_rd[w_tail] <= i_push_rd;
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage issue gate: RAW hazards against in-flight writes, scoreboard
// capacity, mispredict flush with a one-cycle hold, and stall/order monitors.
module decode_hazard_ctrl
    import common::hazard_state_t;
    import common::RUN;
    import common::FLUSH_HOLD;
#(
    parameter int SB_DEPTH = common::SB_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [4:0]                id_rs1,
    input  logic [4:0]                id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [4:0]                id_rd,
    input  logic                      id_rd_write,
    output logic                      id_ready,
    input  logic                      wb_en,
    input  logic [4:0]                wb_id,
    input  logic                      flush,
    input  logic [2:0]                flush_keep,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic [15:0]               stall_cnt,
    output logic                      order_err
);

    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    hazard_state_t r_state;
    hazard_state_t w_state_next;
    logic          w_hold;
    logic          w_hazard;
    logic          w_full;
    logic          w_fire;
    logic          w_push;
    logic          w_pop_ok;
    logic [31:0]   w_busy;
    logic [31:0]   w_busy_nohead;
    logic [31:0]   w_busy_eff;
    logic [15:0]   r_stall_cnt;
    logic          r_order_err;

    sb_queue #(.DEPTH(SB_DEPTH)) u_sb_queue (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_rd     (id_rd),
        .i_pop_req     (wb_en),
        .i_pop_id      (wb_id),
        .i_trunc       (flush),
        .i_keep        (flush_keep),
        .o_count       (sb_count),
        .o_pop_ok      (w_pop_ok),
        .o_busy        (w_busy),
        .o_busy_nohead (w_busy_nohead)
    );

    // A head entry retiring this cycle is written through the regfile, so it no longer blocks.
    always_comb begin
        w_busy_eff    = w_pop_ok ? w_busy_nohead : w_busy;
        w_busy_eff[0] = 1'b0;
        w_hazard      = (id_rs1_used && w_busy_eff[id_rs1]) ||
                        (id_rs2_used && w_busy_eff[id_rs2]);
        w_full        = (sb_count == CNT_W'(SB_DEPTH));
        id_ready      = !(w_hazard || w_full || flush || w_hold);
    end

    assign w_fire = id_valid && id_ready;
    assign w_push = w_fire && id_rd_write && (id_rd != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:        w_state_next = flush ? FLUSH_HOLD : RUN;
            FLUSH_HOLD: w_state_next = flush ? FLUSH_HOLD : RUN;
            default:    w_state_next = RUN;
        endcase
    end

    always_comb begin
        w_hold = (r_state == FLUSH_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
            r_order_err <= 1'b0;
        end else begin
            if (id_valid && !id_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (wb_en && !w_pop_ok)
                r_order_err <= 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign order_err = r_order_err;

endmodule
